board_row_fetch: RTL and testbench
==================================

// Module: board_row_fetch
// PURPOSE
//  Board store and row-fetch stage that sits directly upstream of the VGA colour mapper.
//  - Holds the 10x20 Tetris playfield as 16-bit cells.
//  - Accepts single-cell writes from the game logic.
//  - When the colour mapper requests a board row (LD_Row/rowNum), it reads that row
//    one cell per cycle into a shadow buffer.
//  - It then commits the whole row at once to Row[], so the display never sees a
//    half-updated row.
// PARAMETERS
//  BOARD_COLS  10  cells per row (Row[] depth)
//  BOARD_ROWS  20  rows in the playfield; rowNum >= BOARD_ROWS is out of range
//  CELL_W      16  cell width; [11:8]=R, [7:4]=G, [3:0]=B nibbles, [15:12] flags;
//                  [11:4]==0 means an empty cell
// PORTS
//  Clk        in   1            system clock
//  reset      in   1            synchronous, active-high reset
//  LD_Row     in   1            row load request (level; only the rising edge is acted on)
//  rowNum     in   8            row index to fetch, sampled on the LD_Row rising edge
//  wr_en      in   1            game-logic cell write strobe
//  wr_row     in   5            write row index
//  wr_col     in   4            write column index
//  wr_data    in   CELL_W       write cell value
//  Row        out  CELL_W x10   committed row seen by the colour mapper
//  rowReady   out  1            one-cycle pulse; Row[] updated this cycle
//  busy       out  1            fetch in progress (FETCH or COMMIT state)
// BEHAVIOUR
//  - Reset: state=IDLE, Row[*]=0, shadow=0, rowReady=0, busy=0, edge register=0.
//    Board memory is NOT cleared by reset; game logic clears it with writes.
//  - Memory: 200-entry synchronous RAM, addr = row*10+col, one write port and one
//    read port, read latency 1.
//  - Edge detect: ld_q <= LD_Row each cycle; a request is LD_Row & ~ld_q.
//  - FSM IDLE: on a request in cycle T, latch rowNum -> go to FETCH, col=0.
//  - FSM FETCH: issue a read of col 0..9 on cycles T+1..T+10; read data lands in
//    shadow[col] on T+2..T+11. After the last issue -> COMMIT.
//  - FSM COMMIT (T+12): Row <= shadow, rowReady=1 for exactly one cycle -> IDLE.
//  - Latency from request edge to rowReady is exactly 12 cycles.
//  - Request while busy: ignored and not queued. The caller must wait for rowReady.
//  - LD_Row held high: counts as one request only; a new request needs a low cycle first.
//  - rowNum >= BOARD_ROWS: no RAM reads. Shadow is zero-filled, same 12-cycle timing,
//    and the commit produces an all-empty row.
//  - Write/read same cell in the same cycle: the read returns the OLD value. The write
//    is visible to the next fetch.
//  - Write with wr_row >= BOARD_ROWS or wr_col >= BOARD_COLS: dropped, memory unchanged.
//  - Row[] changes ONLY in COMMIT (or on reset) and holds stable otherwise.
//  - Reset asserted mid-FETCH: fetch is aborted and no rowReady is produced. Row[]=0
//    on the next cycle; memory is untouched.
//  - Index arithmetic: addr uses 8-bit unsigned (max 199); col counter is 4 bits,
//    row latch is 8 bits.
// CONFIGURATION
//  PIECE_OVERLAY_EN
//   - Defined: adds ports piece_valid(1), piece_x[4](4 each), piece_y[4](5 each),
//     piece_cell(CELL_W).
//   - Defined: during commit, any column c with piece_valid && piece_x[k]==c &&
//     piece_y[k]==latched row (for any k in 0..3) takes piece_cell instead of the
//     RAM value.
//   - Defined: piece inputs are sampled in the COMMIT cycle; they do not affect the
//     memory or the 12-cycle latency.
//   - Undefined: the ports are absent and Row[] is pure memory contents.
// TESTING
//  1. Reset, then write row 5 col 3 = 16'h0F00 and pulse LD_Row with rowNum=5
//     -> rowReady exactly 12 cycles later; Row[3]=16'h0F00, all other Row[]=0.
//  2. Hold LD_Row high for 30 cycles with rowNum=2 -> exactly one rowReady pulse.
//     A second rising edge 3 cycles after the first is ignored: one pulse, data of
//     the first request.
//  3. rowNum=25 with RAM preloaded nonzero -> rowReady at +12 and Row[*]=0.
//     Write with wr_row=20 -> a later fetch shows no change.
//  4. Write (row 0, col 4, 16'h00F0) in the same cycle col 4 is read for row 0, with
//     the old value 0 -> Row[4]=0; an immediate refetch gives Row[4]=16'h00F0.
//  5. Assert reset at T+6 of a fetch -> no rowReady, Row[*]=0, busy=0.
//     A refetch of the same row returns the pre-reset memory contents.
//  6. With PIECE_OVERLAY_EN: piece_valid=1, piece at (1,7),(2,7),(3,7),(3,8),
//     piece_cell=16'h0FF0, fetch row 7 over an empty board -> Row[1..3]=16'h0FF0,
//     Row[0]=0, Row[4..9]=0.
//     Without the macro, the same stimulus gives Row[*]=0.

Source files
------------

// File: rtl/board_row_fetch.sv
// Tetris board store with atomic row fetch for the VGA colour mapper.
// Optional macro PIECE_OVERLAY_EN overlays the falling piece onto the committed row.
module board_row_fetch #(
  parameter int BOARD_COLS = 10,
  parameter int BOARD_ROWS = 20,
  parameter int CELL_W     = 16
) (
  input  logic                                  Clk,
  input  logic                                  reset,
  input  logic                                  LD_Row,
  input  logic [7:0]                            rowNum,
  input  logic                                  wr_en,
  input  logic [4:0]                            wr_row,
  input  logic [3:0]                            wr_col,
  input  logic [CELL_W-1:0]                     wr_data,
`ifdef PIECE_OVERLAY_EN
  input  logic                                  piece_valid,
  input  logic [3:0][3:0]                       piece_x,
  input  logic [3:0][4:0]                       piece_y,
  input  logic [CELL_W-1:0]                     piece_cell,
`endif
  output logic [BOARD_COLS-1:0][CELL_W-1:0]     Row,
  output logic                                  rowReady,
  output logic                                  busy
);

  localparam int DEPTH = BOARD_COLS * BOARD_ROWS;

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN, COMMIT} state_t;

  state_t                             state_q, state_d;
  logic                               ld_q;
  logic [7:0]                         row_q, row_d;
  logic [3:0]                         col_q, col_d;
  logic                               req;
  logic                               row_ok;
  logic                               wr_ok;
  logic [7:0]                         rd_addr;
  logic [7:0]                         wr_addr;
  logic [CELL_W-1:0]                  mem [DEPTH];
  logic signed [CELL_W-1:0]           rd_data_p1;
  logic                               vld_p1;
  logic [3:0]                         col_p1;
  logic [BOARD_COLS-1:0][CELL_W-1:0]  shadow_q;
  logic [BOARD_COLS-1:0][CELL_W-1:0]  commit_row;
  logic [BOARD_COLS-1:0][CELL_W-1:0]  row_out_q;
  logic                               rdy_q;

  assign req     = LD_Row & ~ld_q;
  assign row_ok  = row_q < 8'(BOARD_ROWS);
  assign wr_ok   = (wr_row < 5'(BOARD_ROWS)) && (wr_col < 4'(BOARD_COLS));
  assign rd_addr = row_q * 8'(BOARD_COLS) + {4'b0, col_q};
  assign wr_addr = {3'b0, wr_row} * 8'(BOARD_COLS) + {4'b0, wr_col};

  // Board RAM: no reset, so a reset mid-game keeps the playfield intact.
  always_ff @(posedge Clk) begin
    if (wr_en && wr_ok) mem[wr_addr] <= wr_data;
  end

  // Stage p0 -> p1: RAM read; out-of-range rows read as empty.
  always_ff @(posedge Clk) begin
    if (state_q == FETCH && row_ok) rd_data_p1 <= mem[rd_addr];
    else                            rd_data_p1 <= '0;
    col_p1 <= col_q;
  end

  always_ff @(posedge Clk) begin
    if (reset) vld_p1 <= 1'b0;
    else       vld_p1 <= (state_q == FETCH);
  end

  // Stage p1 -> shadow: assemble the row off-screen.
  always_ff @(posedge Clk) begin
    if (reset)       shadow_q         <= '0;
    else if (vld_p1) shadow_q[col_p1] <= rd_data_p1;
  end

  always_comb begin
    commit_row = shadow_q;
`ifdef PIECE_OVERLAY_EN
    for (int c = 0; c < BOARD_COLS; c++) begin
      for (int k = 0; k < 4; k++) begin
        if (piece_valid && piece_x[k] == 4'(c) && {3'b0, piece_y[k]} == row_q)
          commit_row[c] = piece_cell;
      end
    end
`endif
  end

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    col_d   = col_q;
    case (state_q)
      IDLE: begin
        if (req) begin
          row_d   = rowNum;
          col_d   = '0;
          state_d = FETCH;
        end
      end
      FETCH: begin
        col_d = col_q + 4'd1;
        if (col_q == 4'(BOARD_COLS - 1)) state_d = DRAIN;
      end
      DRAIN:   state_d = COMMIT;
      COMMIT:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (reset) begin
      state_q   <= IDLE;
      ld_q      <= 1'b0;
      row_q     <= '0;
      col_q     <= '0;
      row_out_q <= '0;
      rdy_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      ld_q    <= LD_Row;
      row_q   <= row_d;
      col_q   <= col_d;
      rdy_q   <= (state_q == COMMIT);
      if (state_q == COMMIT) row_out_q <= commit_row;
    end
  end

  assign Row      = row_out_q;
  assign rowReady = rdy_q;
  assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_board_row_fetch.sv
// Bench for board_row_fetch: vector table, corner sequences and random fetches vs a board model.
module tb_board_row_fetch;

  logic               Clk = 1'b0;
  logic               reset;
  logic               LD_Row;
  logic [7:0]         rowNum;
  logic               wr_en;
  logic [4:0]         wr_row;
  logic [3:0]         wr_col;
  logic [15:0]        wr_data;
  logic [9:0][15:0]   Row;
  logic               rowReady;
  logic               busy;
`ifdef PIECE_OVERLAY_EN
  logic               piece_valid;
  logic [3:0][3:0]    piece_x;
  logic [3:0][4:0]    piece_y;
  logic [15:0]        piece_cell;
`endif

  board_row_fetch dut (
    .Clk(Clk), .reset(reset), .LD_Row(LD_Row), .rowNum(rowNum),
    .wr_en(wr_en), .wr_row(wr_row), .wr_col(wr_col), .wr_data(wr_data),
`ifdef PIECE_OVERLAY_EN
    .piece_valid(piece_valid), .piece_x(piece_x), .piece_y(piece_y), .piece_cell(piece_cell),
`endif
    .Row(Row), .rowReady(rowReady), .busy(busy)
  );

  always #5 Clk = ~Clk;

  logic [15:0]   mem_m [200];
  logic [159:0]  last_exp;
  int            n_cmp = 0;
  int            n_bad = 0;

  typedef struct {
    int          wr_r;
    int          wr_c;
    logic [15:0] d;
    int          fr;
    int          cc;
    logic [15:0] exp_cell;
  } vec_t;

  vec_t vecs [6];

  task automatic chk(input string nm, input logic [159:0] act, input logic [159:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [159:0] exp_row(input int r);
    logic [9:0][15:0] e;
    e = '0;
    if (r < 20)
      for (int c = 0; c < 10; c++) e[c] = mem_m[r*10 + c];
`ifdef PIECE_OVERLAY_EN
    if (piece_valid)
      for (int k = 0; k < 4; k++)
        if (int'(piece_x[k]) < 10 && int'(piece_y[k]) == r) e[piece_x[k]] = piece_cell;
`endif
    return e;
  endfunction

  task automatic write_cell(input int r, input int c, input logic [15:0] d);
    wr_en = 1'b1; wr_row = 5'(r); wr_col = 4'(c); wr_data = d;
    @(posedge Clk); #1;
    wr_en = 1'b0;
    if (r < 20 && c < 10) mem_m[r*10 + c] = d;
  endtask

  task automatic do_fetch(input int r, input string nm);
    logic [159:0] e;
    int n;
    e = exp_row(r);
    LD_Row = 1'b1; rowNum = 8'(r);
    @(posedge Clk); #1;
    LD_Row = 1'b0;
    n = 0;
    while (!rowReady && n < 20) begin
      @(posedge Clk); #1;
      n++;
    end
    chk({nm, " latency"}, 160'(n), 160'd12);
    chk({nm, " row"}, Row, e);
    last_exp = e;
    @(posedge Clk); #1;
    chk({nm, " pulse_width"}, 160'(rowReady), 160'd0);
  endtask

  initial begin
    int pulses;
    logic [159:0] e;
    logic [159:0] seen;

    reset = 1'b1; LD_Row = 1'b0; rowNum = '0;
    wr_en = 1'b0; wr_row = '0; wr_col = '0; wr_data = '0;
`ifdef PIECE_OVERLAY_EN
    piece_valid = 1'b0; piece_x = '0; piece_y = '0; piece_cell = '0;
`endif
    repeat (3) @(posedge Clk);
    #1;
    chk("reset Row", Row, '0);
    chk("reset busy", 160'(busy), 160'd0);
    chk("reset rowReady", 160'(rowReady), 160'd0);
    reset = 1'b0;

    for (int i = 0; i < 200; i++) write_cell(i / 10, i % 10, 16'h0000);

    vecs[0] = '{wr_r: 5,  wr_c: 3,  d: 16'h0F00, fr: 5,  cc: 3, exp_cell: 16'h0F00};
    vecs[1] = '{wr_r: 5,  wr_c: 9,  d: 16'h0123, fr: 5,  cc: 9, exp_cell: 16'h0123};
    vecs[2] = '{wr_r: 1,  wr_c: 12, d: 16'hBEEF, fr: 2,  cc: 2, exp_cell: 16'h0000};
    vecs[3] = '{wr_r: 19, wr_c: 9,  d: 16'hFFFF, fr: 19, cc: 9, exp_cell: 16'hFFFF};
    vecs[4] = '{wr_r: 20, wr_c: 0,  d: 16'hABCD, fr: 0,  cc: 0, exp_cell: 16'h0000};
    vecs[5] = '{wr_r: 0,  wr_c: 5,  d: 16'h0555, fr: 26, cc: 1, exp_cell: 16'h0000};
    for (int i = 0; i < 6; i++) begin
      write_cell(vecs[i].wr_r, vecs[i].wr_c, vecs[i].d);
      do_fetch(vecs[i].fr, $sformatf("vec%0d", i));
      chk($sformatf("vec%0d cell", i), 160'(Row[vecs[i].cc]), 160'(vecs[i].exp_cell));
    end

    // Row holds while the board changes underneath it.
    do_fetch(5, "hold");
    write_cell(5, 3, 16'h0111);
    write_cell(5, 4, 16'h0222);
    repeat (3) @(posedge Clk);
    #1;
    chk("hold stable", Row, last_exp);

    // Out-of-range fetch with nonzero RAM content.
    do_fetch(25, "row25");
    chk("row25 empty", Row, '0);

    // LD_Row held high for 30 cycles.
    write_cell(2, 0, 16'h1234);
    e = exp_row(2);
    pulses = 0;
    LD_Row = 1'b1; rowNum = 8'd2;
    for (int i = 0; i < 30; i++) begin
      @(posedge Clk); #1;
      if (rowReady) pulses++;
    end
    LD_Row = 1'b0;
    repeat (5) begin
      @(posedge Clk); #1;
      if (rowReady) pulses++;
    end
    chk("held pulses", 160'(pulses), 160'd1);
    chk("held row", Row, e);

    // Second rising edge while busy is ignored.
    e = exp_row(2);
    seen = '0;
    pulses = 0;
    LD_Row = 1'b1; rowNum = 8'd2;
    @(posedge Clk); #1;
    LD_Row = 1'b0;
    @(posedge Clk); #1;
    @(posedge Clk); #1;
    LD_Row = 1'b1; rowNum = 8'd5;
    @(posedge Clk); #1;
    LD_Row = 1'b0;
    for (int i = 0; i < 25; i++) begin
      @(posedge Clk); #1;
      if (rowReady) begin
        pulses++;
        seen = Row;
      end
    end
    chk("busy req pulses", 160'(pulses), 160'd1);
    chk("busy req row", seen, e);

    // Write to row 0 col 4 in the same cycle that cell is read.
    e = exp_row(0);
    LD_Row = 1'b1; rowNum = 8'd0;
    @(posedge Clk); #1;
    LD_Row = 1'b0;
    repeat (4) begin
      @(posedge Clk); #1;
    end
    wr_en = 1'b1; wr_row = 5'd0; wr_col = 4'd4; wr_data = 16'h00F0;
    @(posedge Clk); #1;
    wr_en = 1'b0;
    mem_m[4] = 16'h00F0;
    pulses = 0;
    while (!rowReady && pulses < 20) begin
      @(posedge Clk); #1;
      pulses++;
    end
    chk("rw collide latency", 160'(pulses), 160'd7);
    chk("rw collide old", 160'(Row[4]), 160'h0);
    chk("rw collide row", Row, e);
    @(posedge Clk); #1;
    do_fetch(0, "refetch");
    chk("refetch cell", 160'(Row[4]), 160'h00F0);

    // Reset mid-fetch.
    LD_Row = 1'b1; rowNum = 8'd5;
    @(posedge Clk); #1;
    LD_Row = 1'b0;
    repeat (6) begin
      @(posedge Clk); #1;
    end
    reset = 1'b1;
    @(posedge Clk); #1;
    chk("midreset Row", Row, '0);
    chk("midreset busy", 160'(busy), 160'd0);
    reset = 1'b0;
    pulses = 0;
    for (int i = 0; i < 15; i++) begin
      @(posedge Clk); #1;
      if (rowReady) pulses++;
    end
    chk("midreset pulses", 160'(pulses), 160'd0);
    do_fetch(5, "post reset");

    // Piece overlay onto an empty row 7.
    for (int c = 0; c < 10; c++) write_cell(7, c, 16'h0000);
`ifdef PIECE_OVERLAY_EN
    piece_valid = 1'b1; piece_cell = 16'h0FF0;
    piece_x[0] = 4'd1; piece_y[0] = 5'd7;
    piece_x[1] = 4'd2; piece_y[1] = 5'd7;
    piece_x[2] = 4'd3; piece_y[2] = 5'd7;
    piece_x[3] = 4'd3; piece_y[3] = 5'd8;
    do_fetch(7, "overlay");
    chk("overlay const", Row, {96'h0, 16'h0FF0, 16'h0FF0, 16'h0FF0, 16'h0});
    piece_valid = 1'b0;
`else
    do_fetch(7, "overlay");
    chk("overlay const", Row, '0);
`endif

    // Random writes and fetches against the board model.
    for (int i = 0; i < 30; i++) begin
      for (int j = 0; j < 3; j++)
        write_cell(int'($urandom_range(23, 0)), int'($urandom_range(11, 0)), 16'($urandom));
      do_fetch(int'($urandom_range(27, 0)), $sformatf("rand%0d", i));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got no finish, expected finish");
    $fatal(1);
  end

endmodule
